// File: rtl/switch_collector_pkg.sv
// Shared definitions for the operator-entry front end and the display driver.
package switch_collector_pkg;

    // Display/FSM state encoding; the display driver decodes these same values.
    typedef enum logic [1:0] {
        S_SEL = 2'b00,
        S_A   = 2'b01,
        S_B   = 2'b10,
        S_RUN = 2'b11
    } state_e;

    localparam int SW_W   = 8;
    localparam int MODE_W = 4;

endpackage

// File: rtl/switch_collector_btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a
// single-clock press pulse on an accepted 0->1 level change.
module switch_collector_btn_debounce #(
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic press_o
);

    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [DEB_W-1:0] cnt_r;
    logic             press_r;

    // Bring the raw level into the clock domain before anything looks at it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw_i;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after it has differed from the stable level for
    // DEB_CYCLES consecutive clocks; pulse once when the accepted level is 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_r <= 1'b0;
            cnt_r    <= '0;
            press_r  <= 1'b0;
        end else if (sync2_r == stable_r) begin
            cnt_r   <= '0;
            press_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            stable_r <= sync2_r;
            cnt_r    <= '0;
            press_r  <= sync2_r;
        end else begin
            cnt_r   <= cnt_r + DEB_W'(1);
            press_r <= 1'b0;
        end
    end

    assign press_o = press_r;

endmodule

// File: rtl/switch_collector.sv
// Operator-entry front end: switch synchroniser, debounced confirm/back
// buttons and the select -> A -> B -> run FSM feeding display and compute core.
module switch_collector
    import switch_collector_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw_i,
    input  logic              confirm_i,
    input  logic              back_i,
    output logic [1:0]        state_o,
    output logic [MODE_W-1:0] mode_o,
    output logic [SW_W-1:0]   a_o,
    output logic [SW_W-1:0]   b_o,
    output logic              start_o,
    output logic              valid_o
);

    logic [SW_W-1:0]   sw_meta_r;
    logic [SW_W-1:0]   sw_sync_r;
    logic              confirm_press_s;
    logic              back_press_s;
    state_e            state_r;
    state_e            next_state_s;
    logic [MODE_W-1:0] mode_r;
    logic [MODE_W-1:0] mode_nxt_s;
    logic [SW_W-1:0]   a_r;
    logic [SW_W-1:0]   a_nxt_s;
    logic [SW_W-1:0]   b_r;
    logic [SW_W-1:0]   b_nxt_s;
    logic              start_r;
    logic              valid_r;

    // Two-flop synchroniser for the slide switches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_r <= '0;
            sw_sync_r <= '0;
        end else begin
            sw_meta_r <= sw_i;
            sw_sync_r <= sw_meta_r;
        end
    end

    switch_collector_btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .DEB_W     (DEB_W)
    ) u_confirm_deb (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (confirm_i),
        .press_o(confirm_press_s)
    );

    switch_collector_btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .DEB_W     (DEB_W)
    ) u_back_deb (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (back_i),
        .press_o(back_press_s)
    );

    // Next state and next operand/mode values; back always beats confirm.
    always_comb begin
        next_state_s = state_r;
        mode_nxt_s   = mode_r;
        a_nxt_s      = a_r;
        b_nxt_s      = b_r;
        case (state_r)
            S_SEL: begin
                mode_nxt_s = sw_sync_r[MODE_W-1:0];
                if (back_press_s) begin
                    next_state_s = S_SEL;
                end else if (confirm_press_s) begin
                    next_state_s = S_A;
                end else begin
                    next_state_s = S_SEL;
                end
            end
            S_A: begin
                if (back_press_s) begin
                    next_state_s = S_SEL;
                end else if (confirm_press_s) begin
                    a_nxt_s      = sw_sync_r;
                    next_state_s = S_B;
                end else begin
                    next_state_s = S_A;
                end
            end
            S_B: begin
                if (back_press_s) begin
                    next_state_s = S_A;
                end else if (confirm_press_s) begin
                    b_nxt_s      = sw_sync_r;
                    next_state_s = S_RUN;
                end else begin
                    next_state_s = S_B;
                end
            end
            S_RUN: begin
                if (back_press_s) begin
                    next_state_s = S_B;
                end else if (confirm_press_s) begin
                    next_state_s = S_SEL;
                end else begin
                    next_state_s = S_RUN;
                end
            end
            default: begin
                next_state_s = S_SEL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_SEL;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs; start fires on the clock that enters S_RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r  <= '0;
            a_r     <= '0;
            b_r     <= '0;
            start_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            mode_r  <= mode_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            start_r <= (next_state_s == S_RUN) && (state_r != S_RUN);
            valid_r <= (next_state_s == S_RUN);
        end
    end

    assign state_o = state_r;
    assign mode_o  = mode_r;
    assign a_o     = a_r;
    assign b_o     = b_r;
    assign start_o = start_r;
    assign valid_o = valid_r;

endmodule

// File: tb/tb_switch_collector.sv
// Self-checking bench for switch_collector: vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_switch_collector;

    localparam int DEB   = 4;
    localparam int DEB_W = 3;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic       confirm;
    logic       back;
    logic [1:0] state_o;
    logic [3:0] mode_o;
    logic [7:0] a_o;
    logic [7:0] b_o;
    logic       start_o;
    logic       valid_o;

    int total = 0;
    int bad   = 0;

    switch_collector #(.DEB_CYCLES(DEB), .DEB_W(DEB_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_i     (sw),
        .confirm_i(confirm),
        .back_i   (back),
        .state_o  (state_o),
        .mode_o   (mode_o),
        .a_o      (a_o),
        .b_o      (b_o),
        .start_o  (start_o),
        .valid_o  (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Buttons index 0 = confirm, 1 = back. A level is accepted once the last
    // DEB synchronised samples all disagree with the current accepted level.
    logic [7:0] m_sw_d1, m_sw_d2;
    bit         m_d1 [2];
    bit         m_d2 [2];
    bit         m_hist [2][$];
    bit         m_lvl [2];
    bit         m_press [2];
    int         m_state;
    logic [3:0] m_mode;
    logic [7:0] m_a, m_b;
    bit         m_start;

    task automatic model_reset();
        m_sw_d1 = 8'h00; m_sw_d2 = 8'h00;
        for (int k = 0; k < 2; k++) begin
            m_d1[k] = 1'b0; m_d2[k] = 1'b0; m_lvl[k] = 1'b0; m_press[k] = 1'b0;
            m_hist[k].delete();
        end
        m_state = 0; m_mode = 4'h0; m_a = 8'h00; m_b = 8'h00; m_start = 1'b0;
    endtask

    task automatic model_step();
        int prev;
        prev = m_state;
        m_start = 1'b0;
        if (prev == 0) m_mode = m_sw_d2[3:0];
        if (m_press[1]) begin
            if (prev > 0) m_state = prev - 1;
        end else if (m_press[0]) begin
            if (prev == 1) m_a = m_sw_d2;
            if (prev == 2) begin
                m_b = m_sw_d2;
                m_start = 1'b1;
            end
            m_state = (prev + 1) % 4;
        end
        for (int k = 0; k < 2; k++) begin
            bit differ;
            differ = 1'b1;
            m_hist[k].push_back(m_d2[k]);
            if (m_hist[k].size() > DEB) void'(m_hist[k].pop_front());
            m_press[k] = 1'b0;
            if (m_hist[k].size() == DEB) begin
                foreach (m_hist[k][j]) if (m_hist[k][j] == m_lvl[k]) differ = 1'b0;
                if (differ) begin
                    m_lvl[k]   = ~m_lvl[k];
                    m_press[k] = m_lvl[k];
                end
            end
        end
        m_sw_d2 = m_sw_d1; m_sw_d1 = sw;
        m_d2[0] = m_d1[0]; m_d1[0] = confirm;
        m_d2[1] = m_d1[1]; m_d1[1] = back;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("m_state", {6'd0, state_o}, 8'(m_state));
        check("m_mode",  {4'd0, mode_o}, {4'd0, m_mode});
        check("m_a",     a_o, m_a);
        check("m_b",     b_o, m_b);
        check("m_start", {7'd0, start_o}, {7'd0, m_start});
        check("m_valid", {7'd0, valid_o}, {7'd0, (m_state == 3)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, {6'd0, state_o}, 8'h00);
        check({tag, "_mode"},  {4'd0, mode_o}, 8'h00);
        check({tag, "_a"},     a_o, 8'h00);
        check({tag, "_b"},     b_o, 8'h00);
        check({tag, "_start"}, {7'd0, start_o}, 8'h00);
        check({tag, "_valid"}, {7'd0, valid_o}, 8'h00);
    endtask

    // Assert reset between edges and confirm outputs clear before the next edge.
    task automatic mid_clock_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_zero(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] sw;
        logic       c;
        logic       bk;
        int         hold;
        logic [1:0] st;
        logic [3:0] md;
        logic [7:0] a;
        logic [7:0] b;
        int         starts;
    } vec_t;

    vec_t vecs [16];

    int starts_seen;
    int trans;
    logic [1:0] prev_st;

    task automatic run_counting(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (state_o != prev_st) trans++;
            prev_st = state_o;
        end
    endtask

    initial begin
        vecs[0]  = '{8'h05, 1'b0, 1'b0, 3,  2'd0, 4'h5, 8'h00, 8'h00, 0};
        vecs[1]  = '{8'h03, 1'b0, 1'b0, 4,  2'd0, 4'h3, 8'h00, 8'h00, 0};
        vecs[2]  = '{8'h03, 1'b1, 1'b0, 10, 2'd1, 4'h3, 8'h00, 8'h00, 0};
        vecs[3]  = '{8'h12, 1'b0, 1'b0, 10, 2'd1, 4'h3, 8'h00, 8'h00, 0};
        vecs[4]  = '{8'h12, 1'b1, 1'b0, 10, 2'd2, 4'h3, 8'h12, 8'h00, 0};
        vecs[5]  = '{8'hA7, 1'b0, 1'b0, 10, 2'd2, 4'h3, 8'h12, 8'h00, 0};
        vecs[6]  = '{8'hA7, 1'b1, 1'b0, 10, 2'd3, 4'h3, 8'h12, 8'hA7, 1};
        vecs[7]  = '{8'hA7, 1'b0, 1'b0, 10, 2'd3, 4'h3, 8'h12, 8'hA7, 0};
        vecs[8]  = '{8'hA7, 1'b0, 1'b1, 10, 2'd2, 4'h3, 8'h12, 8'hA7, 0};
        vecs[9]  = '{8'hA7, 1'b0, 1'b0, 10, 2'd2, 4'h3, 8'h12, 8'hA7, 0};
        vecs[10] = '{8'h3C, 1'b1, 1'b1, 10, 2'd1, 4'h3, 8'h12, 8'hA7, 0};
        vecs[11] = '{8'hA7, 1'b0, 1'b0, 10, 2'd1, 4'h3, 8'h12, 8'hA7, 0};
        vecs[12] = '{8'hA7, 1'b0, 1'b1, 10, 2'd0, 4'h7, 8'h12, 8'hA7, 0};
        vecs[13] = '{8'hA7, 1'b0, 1'b0, 10, 2'd0, 4'h7, 8'h12, 8'hA7, 0};
        vecs[14] = '{8'hA7, 1'b0, 1'b1, 10, 2'd0, 4'h7, 8'h12, 8'hA7, 0};
        vecs[15] = '{8'hA7, 1'b0, 1'b0, 10, 2'd0, 4'h7, 8'h12, 8'hA7, 0};

        rst = 1'b0; sw = 8'h00; confirm = 1'b0; back = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        // Table: full entry, back stepping, simultaneous press, back in select.
        for (int v = 0; v < 16; v++) begin
            sw = vecs[v].sw; confirm = vecs[v].c; back = vecs[v].bk;
            starts_seen = 0;
            for (int i = 0; i < vecs[v].hold; i++) begin
                tick();
                if (start_o) starts_seen++;
            end
            check($sformatf("v%0d_state", v), {6'd0, state_o}, {6'd0, vecs[v].st});
            check($sformatf("v%0d_mode", v),  {4'd0, mode_o}, {4'd0, vecs[v].md});
            check($sformatf("v%0d_a", v),     a_o, vecs[v].a);
            check($sformatf("v%0d_b", v),     b_o, vecs[v].b);
            check($sformatf("v%0d_valid", v), {7'd0, valid_o}, {7'd0, (vecs[v].st == 2'd3)});
            check($sformatf("v%0d_starts", v), 8'(starts_seen), 8'(vecs[v].starts));
        end

        // Bounce then hold: exactly one 00->01 transition.
        sw = 8'h03; confirm = 1'b0; back = 1'b0;
        ticks(3);
        prev_st = state_o; trans = 0;
        confirm = 1'b1; run_counting(1);
        confirm = 1'b0; run_counting(1);
        confirm = 1'b1; run_counting(1);
        confirm = 1'b0; run_counting(1);
        confirm = 1'b1; run_counting(10);
        check("bounce_state", {6'd0, state_o}, 8'h01);
        check("bounce_trans", 8'(trans), 8'h01);
        confirm = 1'b0; ticks(10);

        // Short 3-clock pulse must not register.
        prev_st = state_o; trans = 0;
        confirm = 1'b1; run_counting(3);
        confirm = 1'b0; run_counting(10);
        check("glitch_state", {6'd0, state_o}, 8'h01);
        check("glitch_trans", 8'(trans), 8'h00);

        // Back to select, then a long hold gives a single step.
        back = 1'b1; ticks(10); back = 1'b0; ticks(10);
        check("back_to_sel", {6'd0, state_o}, 8'h00);
        prev_st = state_o; trans = 0;
        confirm = 1'b1; run_counting(50);
        check("held_state", {6'd0, state_o}, 8'h01);
        check("held_trans", 8'(trans), 8'h01);
        confirm = 1'b0; ticks(10);
        confirm = 1'b1; ticks(10);
        check("second_press", {6'd0, state_o}, 8'h02);

        // Reach S_RUN, then reset between clock edges.
        confirm = 1'b0; ticks(10);
        confirm = 1'b1; ticks(10);
        confirm = 1'b0; ticks(10);
        check("pre_reset_run", {6'd0, state_o}, 8'h03);
        mid_clock_reset("midrst");

        // Fresh entry after reset.
        sw = 8'h09; ticks(4);
        confirm = 1'b1; ticks(10); confirm = 1'b0; ticks(10);
        sw = 8'h55; ticks(4);
        confirm = 1'b1; ticks(10); confirm = 1'b0; ticks(10);
        check("post_rst_state", {6'd0, state_o}, 8'h02);
        check("post_rst_a", a_o, 8'h55);
        check("post_rst_mode", {4'd0, mode_o}, 8'h09);

        // Randomized segments against the model, with occasional resets.
        for (int s = 0; s < 300; s++) begin
            sw      = 8'($urandom);
            confirm = ($urandom_range(0, 2) == 0);
            back    = ($urandom_range(0, 4) == 0);
            ticks($urandom_range(1, 12));
            if ($urandom_range(0, 60) == 0) mid_clock_reset("rnd_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_collector.md
Name: switch_collector

Overview:
- Input-side companion of the 7-segment display driver.
- Samples the 8 slide switches plus a confirm and a back button, debounces both buttons, and runs the operator-entry FSM (select test -> input A -> input B -> execute).
- Drives the 2-bit display state and the 4-bit mode code that the display driver renders.
- Presents latched operands A/B and a start pulse to the compute core.

Parameters:
DEB_CYCLES, 1000000, consecutive stable clocks needed before a button level is accepted (min 2)
DEB_W, 20, width of debounce counter (must hold DEB_CYCLES-1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
sw_i  in  8  raw slide switches, asynchronous
confirm_i  in  1  raw confirm button, active-high, bouncy
back_i  in  1  raw back/cancel button, active-high, bouncy
state_o  out  2  display state: 00 select test, 01 input A, 10 input B, 11 running/done
mode_o  out  4  test index shown on display (bit per digit)
a_o  out  8  latched operand A
b_o  out  8  latched operand B
start_o  out  1  one-cycle pulse on entry to state 11
valid_o  out  1  high while in state 11

Behaviour:
- Reset (rst low, async): state_o=00, mode_o=0000, a_o=0, b_o=0, start_o=0, valid_o=0, debounce counters=0, stable levels=0, sync flops=0.
- Synchronisation: sw_i, confirm_i, back_i each pass through 2 flops before any use.
- Debounce (per button):
  - Counter clears whenever the synced level equals the stable level.
  - Otherwise it increments; at DEB_CYCLES-1 the stable level takes the synced level and the counter clears.
  - Press pulse is 1 clock, generated on a stable 0->1 transition only; release generates nothing.
  - Minimum latency from clean raw edge to press pulse: 2 sync + DEB_CYCLES clocks.
- FSM states S_SEL=00, S_A=01, S_B=10, S_RUN=11; state_o is the state register directly.
  - S_SEL: mode_o follows synced sw[3:0] every clock (live preview). On confirm press: mode_o frozen, go S_A.
  - S_A: on confirm press, a_o <= synced sw[7:0], go S_B.
  - S_B: on confirm press, b_o <= synced sw[7:0], go S_RUN; start_o=1 for the first clock of S_RUN only.
  - S_RUN: valid_o=1; a_o, b_o, mode_o held. Confirm press -> S_SEL, valid_o=0, a_o/b_o keep values until overwritten.
  - Back press: S_A->S_SEL, S_B->S_A, S_RUN->S_B (valid_o drops). In S_SEL it is ignored.
- Simultaneous confirm and back press in the same clock: back wins, confirm is discarded.
- Holding a button generates exactly one press; a second press requires release (stable 0) first.
- Glitches shorter than DEB_CYCLES never change the stable level.
- Reset mid-entry: immediate return to S_SEL with all outputs at reset values. A button still held at reset release produces one press after the debounce time.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package: state encodings S_SEL/S_A/S_B/S_RUN (2-bit), also consumed by the display driver.
- One sub-module, btn_debounce (2-flop sync + counter + rising-edge pulse), parameterised by DEB_CYCLES/DEB_W, instantiated for confirm and back.
- Switch synchroniser and FSM stay in the top.

Test Plan (DEB_CYCLES=4):
- Reset then idle: state_o=00, all outputs 0; sw_i=8'h05 -> mode_o=0101 within 3 clocks, state_o stays 00.
- Full entry: confirm with sw=0x03, then sw=0x12 + confirm, then sw=0xA7 + confirm -> mode_o=0011, a_o=0x12, b_o=0xA7, state_o=11, start_o exactly one clock, valid_o=1.
- Bounce: confirm toggles 1,0,1,0 on single clocks, then held 10 clocks -> exactly one transition 00->01. A 3-clock pulse alone -> no transition.
- Held button: confirm held 50 clocks in S_SEL -> only S_A reached. Release, press again -> S_B.
- Back/simultaneous: in S_B, confirm and back go high on the same clock and are held -> state_o=01, b_o unchanged. Back in S_SEL -> stays 00.
- Async reset in S_RUN mid-clock -> outputs 0 and state_o=00 before the next clk edge. Subsequent entry works normally.
